perf_cnt_readout: RTL and testbench
===================================

// Module: perf_cnt_readout
// PURPOSE
//  Readout side of the I/D cache hit-rate counters. Counts the four fetch/data
//  hit/miss combinations plus stall and total cycles, and on request snapshots
//  all six counters atomically and streams them word by word over a
//  valid/ready port to the debug/trace logic. Sits beside the cache pair in
//  PipelineMIPS/utils.
// PARAMETERS
//  CNT_W     32  counter width, 1..32; words zero-extended to 32 bits
//  SATURATE  1   1: counters stick at all-ones; 0: wrap to 0
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous reset, active-high
//  i_hit      in   1      I-cache hit this cycle
//  i_miss     in   1      I-cache miss this cycle
//  d_hit      in   1      D-cache hit this cycle
//  d_miss     in   1      D-cache miss this cycle
//  stallF     in   1      fetch stage stalled this cycle
//  rd_req     in   1      request snapshot+readout (level, sampled in IDLE)
//  clr_req    in   1      clear all live counters
//  busy       out  1      1 while in SEND
//  out_valid  out  1      out_data/out_idx/out_last valid
//  out_ready  in   1      consumer accepts word
//  out_data   out  32     snapshot word, zero-extended
//  out_idx    out  3      word index 0..5
//  out_last   out  1      1 on word 5
// BEHAVIOUR
//  - Reset: all live and shadow counters 0, FSM IDLE, busy=0, out_valid=0,
//    out_data=0, out_idx=0, out_last=0. Reset mid-readout aborts: outputs
//    return to reset values at that edge; no further words.
//  - Live counters, updated every edge with rst=0:
//    c0 i_hit&d_hit, c1 i_hit&d_miss, c2 i_miss&d_hit, c3 i_miss&d_miss --
//    each counted only when stallF=0; c4 +1 when stallF=1; c5 +1 every cycle.
//    Other input combinations count nothing in c0..c3.
//  - Width: CNT_W-bit; at all-ones, SATURATE=1 holds, SATURATE=0 wraps to 0.
//  - clr_req=1: all live counters <= 0 at that edge; clear beats any increment.
//  - Counting continues in every FSM state; readout never perturbs counts.
//  - FSM IDLE: if rd_req=1 at an edge, shadow[k] <= live c_k (register value
//    before that edge's update, so that cycle's events are excluded), go SEND,
//    out_idx=0, out_valid=1, busy=1 from next cycle. Same-edge clr_req: shadow
//    takes pre-clear values, live counters clear.
//  - FSM SEND: out_data = shadow[out_idx]; out_last = (out_idx==5). On
//    out_valid&out_ready: idx<5 -> idx+1; idx==5 -> IDLE, out_valid=0, busy=0,
//    out_idx=0, out_data=0. Without ready, all outputs held stable.
//  - rd_req ignored while in SEND; a held rd_req re-triggers one cycle after
//    return to IDLE (min 1 idle cycle between streams).
//  - Latency: rd_req edge -> word 0 valid next cycle; 6 words in 6 cycles at
//    full ready.
// TESTING
//  1 rst 3 cyc, release, rd_req at 1st edge, ready=1 -> words 0,0,0,0,0,0
//    idx 0..5, out_last only on idx5, busy 6 cycles.
//  2 5 cyc i_hit&d_hit stallF=0, 3 cyc stallF=1 with i_miss&d_miss, rd_req
//    -> w0=5, w3=0, w4=3, w5=edges since rst release before snapshot edge.
//  3 backpressure: ready=0 for 4 cycles on idx2 -> out_valid=1, out_data and
//    out_idx=2 stable; ready=1 -> idx3 next cycle.
//  4 i_hit&d_miss each cycle during SEND -> streamed w1 unchanged; next
//    read w1 grows by exactly the counted cycles.
//  5 CNT_W=4: 20 cyc i_miss&d_hit -> SATURATE=1 w2=15; SATURATE=0 w2=4.
//  6 clr_req with i_hit&d_hit same cycle -> c0=0 next read; rd_req+clr_req
//    same edge -> stream pre-clear values; rst at idx3 -> out_valid=0 next.

Source files
------------

// File: rtl/perf_cnt_readout.sv
// Cache hit/miss, stall and cycle counters with an atomic snapshot that is
// streamed out as six zero-extended 32-bit words over a valid/ready port.
module perf_cnt_readout #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hit,
  input  logic        i_miss,
  input  logic        d_hit,
  input  logic        d_miss,
  input  logic        stallF,
  input  logic        rd_req,
  input  logic        clr_req,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_idx,
  output logic        out_last
);

  localparam int             NCNT     = 6;
  localparam logic [2:0]     LAST_IDX = 3'd5;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q    [NCNT];
  logic [CNT_W-1:0] cnt_d    [NCNT];
  logic [CNT_W-1:0] shadow_q [NCNT];
  logic [CNT_W-1:0] shadow_d [NCNT];
  logic [NCNT-1:0]  inc;
  logic             snap;

  // Hit/miss pairs are only meaningful while fetch is not stalled.
  always_comb begin
    inc[0] = !stallF & i_hit  & d_hit;
    inc[1] = !stallF & i_hit  & d_miss;
    inc[2] = !stallF & i_miss & d_hit;
    inc[3] = !stallF & i_miss & d_miss;
    inc[4] = stallF;
    inc[5] = 1'b1;
  end

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    for (int k = 0; k < NCNT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr_req) begin
        cnt_d[k] = '0;
      end else if (inc[k]) begin
        if (cnt_q[k] == '1) cnt_d[k] = SATURATE ? cnt_q[k] : '0;
        else                cnt_d[k] = cnt_q[k] + ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          snap    = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot takes the pre-edge live values, so this edge's events and any
  // same-edge clear are excluded from the streamed words.
  always_comb begin
    for (int k = 0; k < NCNT; k++) begin
      shadow_d[k] = snap ? cnt_q[k] : shadow_q[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      // NOTE: the shadow bank is a small register file that must read as zero
      // after reset, so it is reset along with the live counters.
      for (int k = 0; k < NCNT; k++) begin
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int k = 0; k < NCNT; k++) begin
        cnt_q[k]    <= cnt_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign busy      = (state_q == SEND);
  assign out_valid = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign out_data  = (state_q == SEND) ? 32'(shadow_q[idx_q]) : 32'd0;

endmodule

// File: tb/tb_perf_cnt_readout.sv
// Bench for perf_cnt_readout: three instances (32-bit saturating, 4-bit
// saturating, 4-bit wrapping) share stimulus and are compared to one model.
module tb_perf_cnt_readout;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst, i_hit, i_miss, d_hit, d_miss, stallF, rd_req, clr_req, out_ready;

  logic        o_busy  [ND];
  logic        o_valid [ND];
  logic        o_last  [ND];
  logic [31:0] o_data  [ND];
  logic [2:0]  o_idx   [ND];

  int  w_of   [ND] = '{32, 4, 4};
  bit  sat_of [ND] = '{1'b1, 1'b1, 1'b0};

  perf_cnt_readout #(.CNT_W(32), .SATURATE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .i_hit(i_hit), .i_miss(i_miss), .d_hit(d_hit),
    .d_miss(d_miss), .stallF(stallF), .rd_req(rd_req), .clr_req(clr_req),
    .busy(o_busy[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_data(o_data[0]), .out_idx(o_idx[0]), .out_last(o_last[0]));

  perf_cnt_readout #(.CNT_W(4), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_hit(i_hit), .i_miss(i_miss), .d_hit(d_hit),
    .d_miss(d_miss), .stallF(stallF), .rd_req(rd_req), .clr_req(clr_req),
    .busy(o_busy[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_data(o_data[1]), .out_idx(o_idx[1]), .out_last(o_last[1]));

  perf_cnt_readout #(.CNT_W(4), .SATURATE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .i_hit(i_hit), .i_miss(i_miss), .d_hit(d_hit),
    .d_miss(d_miss), .stallF(stallF), .rd_req(rd_req), .clr_req(clr_req),
    .busy(o_busy[2]), .out_valid(o_valid[2]), .out_ready(out_ready),
    .out_data(o_data[2]), .out_idx(o_idx[2]), .out_last(o_last[2]));

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: true event counts since the last clear/reset, narrowed per width.
  longint m_cnt  [6];
  longint m_snap [6];
  bit     m_busy;
  int     m_pos;

  logic [31:0] cap [ND][6];
  int          busy_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] narrow(input longint c, input int w, input bit sat);
    longint mx = (longint'(1) << w) - 1;
    if (sat) return 32'((c > mx) ? mx : c);
    return 32'(c % (mx + 1));
  endfunction

  task automatic model_edge();
    if (rst) begin
      foreach (m_cnt[k]) begin
        m_cnt[k]  = 0;
        m_snap[k] = 0;
      end
      m_busy = 1'b0;
      m_pos  = 0;
    end else begin
      if (!m_busy) begin
        if (rd_req) begin
          foreach (m_cnt[k]) m_snap[k] = m_cnt[k];
          m_busy = 1'b1;
          m_pos  = 0;
        end
      end else if (out_ready) begin
        if (m_pos == 5) begin
          m_busy = 1'b0;
          m_pos  = 0;
        end else begin
          m_pos++;
        end
      end
      if (clr_req) begin
        foreach (m_cnt[k]) m_cnt[k] = 0;
      end else begin
        if (!stallF) begin
          m_cnt[0] += longint'(i_hit  & d_hit);
          m_cnt[1] += longint'(i_hit  & d_miss);
          m_cnt[2] += longint'(i_miss & d_hit);
          m_cnt[3] += longint'(i_miss & d_miss);
        end
        m_cnt[4] += longint'(stallF);
        m_cnt[5] += 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_data;
    for (int i = 0; i < ND; i++) begin
      exp_data = m_busy ? narrow(m_snap[m_pos], w_of[i], sat_of[i]) : 32'd0;
      check($sformatf("d%0d busy", i),  32'(o_busy[i]),  32'(m_busy));
      check($sformatf("d%0d valid", i), 32'(o_valid[i]), 32'(m_busy));
      check($sformatf("d%0d idx", i),   32'(o_idx[i]),   32'(m_pos));
      check($sformatf("d%0d last", i),  32'(o_last[i]),  32'(m_busy && m_pos == 5));
      check($sformatf("d%0d data", i),  o_data[i],       exp_data);
    end
  endtask

  // One clock: record accepted words, advance the edge, update model, compare.
  task automatic step();
    for (int i = 0; i < ND; i++) begin
      if (o_valid[i] === 1'b1 && out_ready === 1'b1 && o_idx[i] < 3'd6)
        cap[i][o_idx[i]] = o_data[i];
    end
    if (o_busy[0] === 1'b1) busy_cnt++;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    i_hit = 0; i_miss = 0; d_hit = 0; d_miss = 0; stallF = 0;
    rd_req = 0; clr_req = 0;
  endtask

  task automatic do_reset();
    idle_in();
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic read_snapshot();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    rd_req    = 1'b0;
    while (o_valid[0] === 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    check("drain done", 32'(o_valid[0]), 32'd0);
  endtask

  initial begin
    idle_in();
    out_ready = 1'b1;
    rst = 1'b1;

    // Reset then immediate read: six zero words, busy for six cycles.
    do_reset();
    busy_cnt = 0;
    read_snapshot();
    drain();
    check("t1 busy cycles", 32'(busy_cnt), 32'd6);
    for (int k = 0; k < 6; k++) check($sformatf("t1 w%0d", k), cap[0][k], 32'd0);

    // Hit counting, stall counting, cycle counter.
    do_reset();
    i_hit = 1; d_hit = 1;
    repeat (5) step();
    idle_in(); stallF = 1; i_miss = 1; d_miss = 1;
    repeat (3) step();
    idle_in();
    read_snapshot();
    drain();
    check("t2 w0", cap[0][0], 32'd5);
    check("t2 w1", cap[0][1], 32'd0);
    check("t2 w3", cap[0][3], 32'd0);
    check("t2 w4", cap[0][4], 32'd3);
    check("t2 w5", cap[0][5], 32'd8);

    // Backpressure on word 2.
    do_reset();
    i_miss = 1; d_hit = 1;
    repeat (7) step();
    idle_in();
    read_snapshot();
    repeat (2) step();
    out_ready = 1'b0;
    repeat (4) begin
      step();
      check("t3 hold valid", 32'(o_valid[0]), 32'd1);
      check("t3 hold idx",   32'(o_idx[0]),   32'd2);
      check("t3 hold data",  o_data[0],       32'd7);
    end
    out_ready = 1'b1;
    step();
    check("t3 resume idx",  32'(o_idx[0]), 32'd3);
    check("t3 resume data", o_data[0],     32'd0);
    drain();

    // Counting during readout is invisible in the current stream.
    do_reset();
    read_snapshot();
    i_hit = 1; d_miss = 1; out_ready = 1;
    repeat (6) step();
    check("t4 first w1", cap[0][1], 32'd0);
    idle_in();
    step();
    read_snapshot();
    drain();
    check("t4 second w1", cap[0][1], 32'd6);

    // Saturate versus wrap on the 4-bit instances.
    do_reset();
    i_miss = 1; d_hit = 1;
    repeat (20) step();
    idle_in();
    read_snapshot();
    drain();
    check("t5 w2 32b", cap[0][2], 32'd20);
    check("t5 w2 sat", cap[1][2], 32'd15);
    check("t5 w2 wrap", cap[2][2], 32'd4);

    // Clear beats a same-cycle increment.
    do_reset();
    i_hit = 1; d_hit = 1;
    repeat (3) step();
    clr_req = 1;
    step();
    idle_in();
    read_snapshot();
    drain();
    check("t6 clr w0", cap[0][0], 32'd0);
    check("t6 clr w5", cap[0][5], 32'd0);

    // Read and clear on the same edge stream the pre-clear values.
    do_reset();
    i_hit = 1; d_hit = 1;
    repeat (3) step();
    idle_in();
    rd_req = 1; clr_req = 1;
    step();
    idle_in();
    drain();
    check("t6 rdclr w0", cap[0][0], 32'd3);
    check("t6 rdclr w5", cap[0][5], 32'd3);

    // Reset in the middle of a stream aborts it.
    read_snapshot();
    repeat (3) step();
    check("t6 pre-rst idx", 32'(o_idx[0]), 32'd3);
    rst = 1;
    step();
    rst = 0;
    check("t6 rst valid", 32'(o_valid[0]), 32'd0);
    check("t6 rst idx",   32'(o_idx[0]),   32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      i_hit     = 1'($urandom_range(0, 1));
      i_miss    = 1'($urandom_range(0, 1));
      d_hit     = 1'($urandom_range(0, 1));
      d_miss    = 1'($urandom_range(0, 1));
      stallF    = ($urandom_range(0, 3) == 0);
      rd_req    = ($urandom_range(0, 3) == 0);
      clr_req   = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;
    idle_in();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
